bcd_count_sequencer: RTL and testbench

Control FSM that sequences a chain of NDIG single-digit BCD up/down counters. It generates the count-step enable at a programmable rate, drives the shared direction and load strobes, and detects the all-zero / all-nine terminal value on the chained counts. In free-run mode it lets the chain wrap; in timer mode it stops at the terminal value. It sits between the debounced front-panel controls and the digit-counter chain, whose `cnt` outputs are concatenated onto `cnt_all`.

---
 rtl/bcd_count_sequencer.sv | 114 +++++++++++
 tb/tb_bcd_count_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_sequencer.sv
// Control FSM for a chain of BCD up/down digit counters: paces the count-step enable,
// drives the shared direction and load strobes, and stops at the terminal value in timer mode.
module bcd_count_sequencer #(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              load_req,
    input  logic              ud_in,
    input  logic              mode_wrap,
    input  logic [4*NDIG-1:0] cnt_all,
    output logic              en_out,
    output logic              ud_out,
    output logic              load_out,
    output logic [2:0]        state,
    output logic              busy,
    output logic              term_hit
);

    localparam int unsigned    PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PrescMax  = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StRun   = 3'd2,
        StPause = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ud_q, ud_d;
    logic          all_zero, all_nine, term, stop_cond;

    // Terminal value depends on the direction currently driven to the chain.
    always_comb begin
        all_zero = 1'b1;
        all_nine = 1'b1;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (cnt_all[4*i +: 4] != 4'd0) all_zero = 1'b0;
            if (cnt_all[4*i +: 4] != 4'd9) all_nine = 1'b0;
        end
        term      = ud_q ? all_zero : all_nine;
        stop_cond = term & ~mode_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            presc_q <= '0;
            ud_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ud_q    <= ud_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ud_d    = ud_q;
        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    state_d = StLoad;
                end else if (start) begin
                    state_d = StRun;
                    ud_d    = ud_in;
                    presc_d = '0;
                end
            end
            StLoad: state_d = StIdle;
            StRun: begin
                if (stop) begin
                    state_d = StPause;
                end else begin
                    presc_d = (presc_q == PrescMax) ? '0 : presc_q + 1'b1;
                    if (stop_cond) state_d = StDone;
                end
            end
            StPause: begin
                // A stop pulse outranks load/start even while already paused.
                if (stop) begin
                    state_d = StPause;
                end else if (load_req) begin
                    state_d = StLoad;
                    presc_d = '0;
                end else if (start) begin
                    state_d = StRun;
                    ud_d    = ud_in;
                end
            end
            StDone: begin
                if (load_req) state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        en_out   = (state_q == StRun) & (presc_q == PrescMax) & ~stop & ~stop_cond;
        ud_out   = ud_q;
        load_out = (state_q == StLoad);
        state    = state_q;
        busy     = (state_q == StRun);
        term_hit = (state_q == StDone);
    end

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Directed bench for bcd_count_sequencer (NDIG=2, TICK_DIV=4) with a behavioural
// two-digit BCD chain driven by the sequencer's enable/direction/load strobes.
module tb_bcd_count_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, load_req = 1'b0, ud_in = 1'b0, mode_wrap = 1'b1;
    logic [7:0] chain = 8'h00;
    logic [7:0] preset = 8'h00;
    logic       en_out, ud_out, load_out, busy, term_hit;
    logic [2:0] state;
    int         en_cnt = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         base;

    bcd_count_sequencer #(.NDIG(2), .TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .load_req  (load_req),
        .ud_in     (ud_in),
        .mode_wrap (mode_wrap),
        .cnt_all   (chain),
        .en_out    (en_out),
        .ud_out    (ud_out),
        .load_out  (load_out),
        .state     (state),
        .busy      (busy),
        .term_hit  (term_hit)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic dn);
        logic [7:0] r;
        logic [3:0] d;
        r = v;
        for (int i = 0; i < 2; i++) begin
            d = r[4*i +: 4];
            if (!dn) begin
                if (d == 4'd9) r[4*i +: 4] = 4'd0;
                else begin r[4*i +: 4] = d + 4'd1; break; end
            end else begin
                if (d == 4'd0) r[4*i +: 4] = 4'd9;
                else begin r[4*i +: 4] = d - 4'd1; break; end
            end
        end
        return r;
    endfunction

    // Digit-chain model plus a running count of issued step enables.
    always @(posedge clk) begin
        if (!rst) begin
            if (load_out)    chain <= preset;
            else if (en_out) chain <= bcd_step(chain, ud_out);
            en_cnt <= en_cnt + (en_out ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step(); step();
        rst = 1'b0;
        check("rst_state", 32'(state), 0);
        check("rst_ud", 32'(ud_out), 0);
        check("rst_en", 32'(en_out), 0);
        check("rst_load", 32'(load_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_term", 32'(term_hit), 0);

        // Load from IDLE
        preset = 8'h00; load_req = 1'b1; step(); load_req = 1'b0;
        check("idle_load_state", 32'(state), 1);
        check("idle_load_out", 32'(load_out), 1);
        step();
        check("idle_load_back", 32'(state), 0);
        check("idle_load_off", 32'(load_out), 0);

        // Up count, free-run
        ud_in = 1'b0; mode_wrap = 1'b1; start = 1'b1; step(); start = 1'b0;
        check("up_busy", 32'(busy), 1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("up_en_%0d", i), 32'(en_out), (i % 4 == 3) ? 1 : 0);
            if (i < 11) step();
        end
        step();
        check("up_cnt", 32'(chain), 32'h03);

        // Pause with prescaler at 1, then resume downward
        step();
        stop = 1'b1;
        check("stop_no_en", 32'(en_out), 0);
        step(); stop = 1'b0;
        check("pause_state", 32'(state), 3);
        base = en_cnt;
        for (int i = 0; i < 20; i++) step();
        check("pause_no_en", 32'(en_cnt - base), 0);
        check("pause_hold", 32'(state), 3);
        ud_in = 1'b1; start = 1'b1; step(); start = 1'b0;
        check("resume_state", 32'(state), 2);
        check("resume_ud", 32'(ud_out), 1);
        check("resume_en0", 32'(en_out), 0);
        step();
        check("resume_en1", 32'(en_out), 0);
        step();
        check("resume_en2", 32'(en_out), 1);
        step();
        check("resume_cnt", 32'(chain), 32'h02);

        // Load from PAUSE
        stop = 1'b1; step(); stop = 1'b0;
        preset = 8'h99; load_req = 1'b1; step(); load_req = 1'b0;
        check("pause_load_state", 32'(state), 1);
        check("pause_load_out", 32'(load_out), 1);
        step();
        check("pause_load_back", 32'(state), 0);
        check("pause_load_cnt", 32'(chain), 32'h99);

        // Wrap 99 -> 00 in free-run
        ud_in = 1'b0; mode_wrap = 1'b1; start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        check("wrap_en", 32'(en_out), 1);
        step();
        check("wrap_cnt", 32'(chain), 32'h00);
        check("wrap_state", 32'(state), 2);

        // load_req ignored in RUN
        load_req = 1'b1; step(); load_req = 1'b0;
        check("run_load_out", 32'(load_out), 0);
        check("run_load_state", 32'(state), 2);

        // stop and load_req together in RUN
        stop = 1'b1; load_req = 1'b1; step(); stop = 1'b0; load_req = 1'b0;
        check("stop_load_state", 32'(state), 3);
        check("stop_load_out", 32'(load_out), 0);

        // Down timer from 03
        preset = 8'h03; load_req = 1'b1; step(); load_req = 1'b0; step();
        check("timer_preset", 32'(chain), 32'h03);
        ud_in = 1'b1; mode_wrap = 1'b0; start = 1'b1; step(); start = 1'b0;
        base = en_cnt;
        for (int i = 0; i < 40; i++) begin
            if (state == 3'd4) break;
            step();
        end
        check("timer_state", 32'(state), 4);
        check("timer_pulses", 32'(en_cnt - base), 3);
        check("timer_cnt", 32'(chain), 32'h00);
        check("timer_term", 32'(term_hit), 1);
        check("timer_busy", 32'(busy), 0);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("done_ignore_start", 32'(state), 4);
        check("done_no_en", 32'(en_cnt - base), 3);

        // Leave DONE via load, then load_req + start together in IDLE
        preset = 8'h00; load_req = 1'b1; step(); load_req = 1'b0;
        check("done_load_state", 32'(state), 1);
        step();
        load_req = 1'b1; start = 1'b1; step(); load_req = 1'b0; start = 1'b0;
        check("load_start_state", 32'(state), 1);
        step();
        check("load_start_back", 32'(state), 0);

        // Start at terminal value
        base = en_cnt;
        ud_in = 1'b1; mode_wrap = 1'b0; start = 1'b1; step(); start = 1'b0;
        check("term_start_run", 32'(state), 2);
        check("term_start_en", 32'(en_out), 0);
        step();
        check("term_start_done", 32'(state), 4);
        check("term_start_pulses", 32'(en_cnt - base), 0);

        // Asynchronous reset mid-RUN while en_out is high
        load_req = 1'b1; step(); load_req = 1'b0; step();
        mode_wrap = 1'b1; ud_in = 1'b1; start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        check("pre_rst_en", 32'(en_out), 1);
        check("pre_rst_ud", 32'(ud_out), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_en", 32'(en_out), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_state", 32'(state), 0);
        step(); rst = 1'b0;
        step();
        check("post_rst_state", 32'(state), 0);
        check("post_rst_ud", 32'(ud_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
